// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two requester handshakes and the shared register-file write
//   port used by regfile_write_arbiter.
//
//   Requester port 0 (pipeline write-back):
//     wb_valid / wb_ready / wb_addr / wb_data
//   Requester port 1 (auxiliary unit):
//     aux_valid / aux_ready / aux_addr / aux_data
//   Register-file side (registered by the arbiter):
//     RegWrite / write_reg / write_data
//   Status:
//     busy : a holding buffer is occupied or a write is being issued
//
//   Modports:
//     master : the requester / register-file environment
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Port 0: pipeline write-back stage
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Port 1: auxiliary unit
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;

  // Shared register-file write port
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  // Activity indication
  logic              busy;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output aux_valid, aux_addr, aux_data,
    input  wb_ready, aux_ready,
    input  RegWrite, write_reg, write_data, busy
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  aux_valid, aux_addr, aux_data,
    output wb_ready, aux_ready,
    output RegWrite, write_reg, write_data, busy
  );

endinterface : regfile_write_arbiter_if

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between two requesters:
//     port 0 = pipeline write-back stage
//     port 1 = auxiliary unit (multi-cycle ALU / debug loader)
//   Each port owns a one-entry holding buffer behind a valid/ready handshake.
//   A round-robin arbiter drains one buffer per cycle into the registered
//   write-port outputs, so the register file sees at most one write per cycle
//   and contending ports alternate strictly.
//
//   Parameters:
//     DATA_W    : write data width
//     ADDR_W    : register index width
//     DROP_ZERO : 1 -> writes to register 0 are accepted and consumed but the
//                 write enable is never raised for them
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset; discards buffered writes and
//           drops RegWrite immediately
//     bus : regfile_write_arbiter_if.slave (handshakes + write port + busy)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_write_arbiter_if.slave    bus
);

  localparam int NUM_PORTS = 2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // A buffered write is swallowed (consumed without a write enable) when it
  // targets the hard-wired zero register and dropping is enabled.
  function automatic logic is_dropped(input logic [ADDR_W-1:0] addr);
    return DROP_ZERO && (addr == {ADDR_W{1'b0}});
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] buf_valid_r;
  logic [ADDR_W-1:0]    buf_addr_r [NUM_PORTS];
  logic [DATA_W-1:0]    buf_data_r [NUM_PORTS];
  logic                 last_grant_r;   // port that won the most recent grant

  logic                 reg_write_r;
  logic [ADDR_W-1:0]    write_reg_r;
  logic [DATA_W-1:0]    write_data_r;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] req_valid_s;
  logic [ADDR_W-1:0]    req_addr_s [NUM_PORTS];
  logic [DATA_W-1:0]    req_data_s [NUM_PORTS];
  logic                 grant_valid_s;
  logic                 grant_id_s;
  logic [NUM_PORTS-1:0] drain_s;
  logic [NUM_PORTS-1:0] ready_s;
  logic [NUM_PORTS-1:0] accept_s;

  // Gather both requester ports into indexable form.
  always_comb begin
    req_valid_s[0] = bus.wb_valid;
    req_addr_s[0]  = bus.wb_addr;
    req_data_s[0]  = bus.wb_data;
    req_valid_s[1] = bus.aux_valid;
    req_addr_s[1]  = bus.aux_addr;
    req_data_s[1]  = bus.aux_data;
  end

  // Round-robin grant: a lone occupant wins outright; on a tie the port that
  // did not win last time is chosen, which makes contending ports alternate.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case (buf_valid_r)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_grant_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  // Ready/accept per port. A buffer that is being drained this edge can take a
  // new request in the same edge, which is what sustains one write per cycle.
  // Ready depends only on registered state, never on the incoming valid.
  always_comb begin
    drain_s  = '0;
    ready_s  = '0;
    accept_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_valid_s && (grant_id_s == 1'(p))) begin
        drain_s[p] = 1'b1;
      end else begin
        drain_s[p] = 1'b0;
      end
      ready_s[p]  = !buf_valid_r[p] || drain_s[p];
      accept_s[p] = req_valid_s[p] && ready_s[p];
    end
  end

  // Holding buffers: capture on accept, release on drain. When both happen in
  // the same edge the new request overwrites the entry whose old contents are
  // simultaneously being issued below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_r <= '0;
      buf_addr_r  <= '{default: '0};
      buf_data_r  <= '{default: '0};
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept_s[p]) begin
          buf_valid_r[p] <= 1'b1;
          buf_addr_r[p]  <= req_addr_s[p];
          buf_data_r[p]  <= req_data_s[p];
        end else if (drain_s[p]) begin
          buf_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  // Write-port issue: present the granted entry to the register file. Index
  // and data follow the granted entry even when it is dropped; only the enable
  // is suppressed. With no grant the index/data simply hold.
  // last_grant resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      last_grant_r <= 1'b1;
    end else if (grant_valid_s) begin
      reg_write_r  <= !is_dropped(buf_addr_r[grant_id_s]);
      write_reg_r  <= buf_addr_r[grant_id_s];
      write_data_r <= buf_data_r[grant_id_s];
      last_grant_r <= grant_id_s;
    end else begin
      reg_write_r  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.wb_ready   = ready_s[0];
  assign bus.aux_ready  = ready_s[1];
  assign bus.RegWrite   = reg_write_r;
  assign bus.write_reg  = write_reg_r;
  assign bus.write_data = write_data_r;
  assign bus.busy       = (|buf_valid_r) | reg_write_r;

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled at that same point, well
//   away from the next active edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  logic clk;
  logic rst;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Sink-side register file model and a counter of writes to the addresses
  // that are discarded by the mid-operation reset.
  logic [31:0] rf [32];
  int          hits_20_21 = 0;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .DROP_ZERO (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture each issued write once per cycle (RegWrite is stable from one
  // rising edge to the next, so the falling edge sees it exactly once).
  always @(negedge clk) begin
    if (bus.RegWrite) begin
      rf[bus.write_reg] <= bus.write_data;
      if (bus.write_reg == 5'd20 || bus.write_reg == 5'd21) begin
        hits_20_21 <= hits_20_21 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
    bus.aux_valid = 1'b0;
    bus.aux_addr  = 5'd0;
    bus.aux_data  = 32'd0;
  endtask

  initial begin
    int          wb_n;
    int          aux_n;
    logic        wb_acc;
    logic        aux_acc;
    int          hits_before;
    logic [31:0] tbl [4];

    tbl = '{32'd16, 32'd6, 32'd256, 32'd5};
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_regwrite",   32'(bus.RegWrite),  32'd0);
    chk("rst_write_reg",  32'(bus.write_reg), 32'd0);
    chk("rst_write_data", bus.write_data,     32'd0);
    chk("rst_busy",       32'(bus.busy),      32'd0);
    chk("rst_wb_ready",   32'(bus.wb_ready),  32'd1);
    chk("rst_aux_ready",  32'(bus.aux_ready), 32'd1);
    rst = 1'b0;
    step();

    // ---------------- 1: single uncontended write ----------------
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_data  = 32'd33;
    chk("t1_wb_ready", 32'(bus.wb_ready), 32'd1);
    step();                                   // acceptance edge
    bus.wb_valid = 1'b0;
    chk("t1_no_write_yet", 32'(bus.RegWrite), 32'd0);
    chk("t1_busy",         32'(bus.busy),     32'd1);
    step();                                   // second edge: write issued
    chk("t1_regwrite",   32'(bus.RegWrite),  32'd1);
    chk("t1_write_reg",  32'(bus.write_reg), 32'd5);
    chk("t1_write_data", bus.write_data,     32'd33);
    step();
    chk("t1_regwrite_off", 32'(bus.RegWrite), 32'd0);
    chk("t1_idle",         32'(bus.busy),     32'd0);

    // ---------------- 2: both ports every cycle ----------------
    do_reset();                               // port 0 wins the first tie
    step();
    wb_n  = 1;
    aux_n = 100;
    for (int k = 1; k <= 10; k++) begin
      bus.wb_valid  = (k <= 8);
      bus.wb_addr   = 5'd10;
      bus.wb_data   = 32'(wb_n);
      bus.aux_valid = (k <= 8);
      bus.aux_addr  = 5'd11;
      bus.aux_data  = 32'(aux_n);
      wb_acc  = bus.wb_valid  && bus.wb_ready;
      aux_acc = bus.aux_valid && bus.aux_ready;
      step();
      if (wb_acc)  wb_n++;
      if (aux_acc) aux_n++;
      if (k <= 8) begin
        chk($sformatf("t2_wb_ready_%0d", k),  32'(bus.wb_ready),  32'((k % 2) == 1));
        chk($sformatf("t2_aux_ready_%0d", k), 32'(bus.aux_ready), 32'((k % 2) == 0));
      end
      if (k >= 2) begin
        chk($sformatf("t2_regwrite_%0d", k), 32'(bus.RegWrite), 32'd1);
        if ((k % 2) == 0) begin
          chk($sformatf("t2_reg_%0d", k),  32'(bus.write_reg), 32'd10);
          chk($sformatf("t2_data_%0d", k), bus.write_data,     32'(1 + (k - 2) / 2));
        end else begin
          chk($sformatf("t2_reg_%0d", k),  32'(bus.write_reg), 32'd11);
          chk($sformatf("t2_data_%0d", k), bus.write_data,     32'(100 + (k - 3) / 2));
        end
      end
    end
    idle_inputs();
    step();
    chk("t2_drained_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("t2_drained_busy",     32'(bus.busy),     32'd0);
    chk("t2_rf10",             rf[10],            32'd5);
    chk("t2_rf11",             rf[11],            32'd103);

    // ---------------- 3: write to register 0 is swallowed ----------------
    bus.aux_valid = 1'b1;
    bus.aux_addr  = 5'd0;
    bus.aux_data  = 32'hDEADBEEF;
    chk("t3_aux_ready_0", 32'(bus.aux_ready), 32'd1);
    step();                                   // r0 request accepted
    bus.aux_addr = 5'd12;
    bus.aux_data = 32'd7;
    chk("t3_aux_ready_1", 32'(bus.aux_ready), 32'd1);
    chk("t3_busy_0",      32'(bus.busy),      32'd1);
    step();                                   // r0 consumed, r12 accepted
    bus.aux_valid = 1'b0;
    chk("t3_dropped",  32'(bus.RegWrite), 32'd0);
    chk("t3_busy_1",   32'(bus.busy),     32'd1);
    step();
    chk("t3_regwrite", 32'(bus.RegWrite),  32'd1);
    chk("t3_reg",      32'(bus.write_reg), 32'd12);
    chk("t3_data",     bus.write_data,     32'd7);
    step();
    chk("t3_idle",     32'(bus.busy),      32'd0);
    chk("t3_rf0",      rf[0],              32'd0);

    // ---------------- 4: same-address tie after a port-0 grant ----------------
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd3;
    bus.wb_data  = 32'd44;
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("t4_pre_reg", 32'(bus.write_reg), 32'd3);
    bus.wb_valid  = 1'b1;
    bus.wb_addr   = 5'd13;
    bus.wb_data   = 32'd18;
    bus.aux_valid = 1'b1;
    bus.aux_addr  = 5'd13;
    bus.aux_data  = 32'd99;
    step();                                   // both accepted
    idle_inputs();
    step();
    chk("t4_first_reg",   32'(bus.write_reg), 32'd13);
    chk("t4_first_data",  bus.write_data,     32'd99);
    step();
    chk("t4_second_data", bus.write_data,     32'd18);
    chk("t4_second_we",   32'(bus.RegWrite),  32'd1);
    step();
    chk("t4_rf13", rf[13], 32'd18);

    // ---------------- 5: reset with both buffers full ----------------
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd22;
    bus.wb_data  = 32'd1;
    step();
    bus.wb_addr   = 5'd20;
    bus.wb_data   = 32'h111;
    bus.aux_valid = 1'b1;
    bus.aux_addr  = 5'd21;
    bus.aux_data  = 32'h222;
    step();                                   // r22 issued, both buffers filled
    idle_inputs();
    chk("t5_pre_regwrite", 32'(bus.RegWrite), 32'd1);
    hits_before = hits_20_21;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_regwrite",  32'(bus.RegWrite),  32'd0);
    chk("t5_rst_busy",      32'(bus.busy),      32'd0);
    chk("t5_rst_wb_ready",  32'(bus.wb_ready),  32'd1);
    chk("t5_rst_aux_ready", 32'(bus.aux_ready), 32'd1);
    chk("t5_rst_write_reg", 32'(bus.write_reg), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_no_stale_write", 32'(hits_20_21 - hits_before), 32'd0);
    chk("t5_idle",           32'(bus.busy),                 32'd0);

    // ---------------- 6: port 0 streaming, port 1 idle ----------------
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'(i + 1);
        bus.wb_data  = tbl[i];
      end else begin
        bus.wb_valid = 1'b0;
      end
      chk($sformatf("t6_wb_ready_%0d", i), 32'(bus.wb_ready), 32'd1);
      step();
      if (i >= 1) begin
        chk($sformatf("t6_regwrite_%0d", i), 32'(bus.RegWrite),  32'd1);
        chk($sformatf("t6_reg_%0d", i),      32'(bus.write_reg), 32'(i));
        chk($sformatf("t6_data_%0d", i),     bus.write_data,     tbl[i - 1]);
      end
    end
    step();
    chk("t6_regwrite_off", 32'(bus.RegWrite), 32'd0);
    chk("t6_rf4",          rf[4],             32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
